// File: rtl/mem_io_pkg.sv
// Shared types, size codes, address map and lane helpers for the MEM-stage
// load/store responder.
package mem_io_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [2:0] {
    RG_NONE, RG_RAM, RG_LEDR, RG_LEDG, RG_HEXLO, RG_HEXHI, RG_LCD, RG_SW
  } region_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] IO_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] HEXL_BASE = 32'h1000_2000;
  localparam logic [31:0] HEXH_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] SW_BASE   = 32'h1001_0000;
  localparam logic [31:0] HEX_MASK  = 32'h7F7F_7F7F;

  function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: byte_en = 4'b0001 << off;
      SZ_H, SZ_HU: byte_en = 4'b0011 << off;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_mask[i*8 +: 8] = {8{be[i]}};
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] size);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      SZ_BU:   load_extend = {24'h0, sh[7:0]};
      SZ_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
      SZ_HU:   load_extend = {16'h0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port data RAM: byte-enable write, registered read (read-before-write).
module dmem_sp_ram #(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_io_responder.sv
// MEM-stage load/store responder: decodes RAM / board I/O, sizes and extends
// data, flags errors and inserts RAM wait states, one request at a time.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int RAM_WAIT    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_size,
  output logic        o_rsp_vld,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  state_e        state_reg;
  logic [3:0]    cnt_reg;
  logic          wren_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic [2:0]    size_reg;
  region_e       region_reg;
  logic          rsp_vld_reg, rsp_err_reg;
  logic [31:0]   rsp_rdata_reg;
  logic [31:0]   ledr_reg, ledg_reg, hex_lo_reg, hex_hi_reg, lcd_reg;
  logic [31:0]   sw_meta_reg, sw_sync_reg;

  region_e       req_region;
  logic          size_ok, align_ok, req_err;
  logic [31:0]   io_word, io_rdata;
  logic [31:0]   ram_rdata, ram_load, wr_data, wr_mask;
  logic [3:0]    wr_be, ram_we;
  logic [AW-1:0] ram_addr;
  logic          zero_wait_load;

  // Decode is done on the live request so the IDLE exit can pick WAIT or RESP.
  always_comb begin
    req_region = RG_NONE;
    if (i_req_addr < RAM_BYTES) begin
      req_region = RG_RAM;
    end else begin
      case (i_req_addr & IO_MASK)
        LEDR_BASE: req_region = RG_LEDR;
        LEDG_BASE: req_region = RG_LEDG;
        HEXL_BASE: req_region = RG_HEXLO;
        HEXH_BASE: req_region = RG_HEXHI;
        LCD_BASE:  req_region = RG_LCD;
        SW_BASE:   req_region = RG_SW;
        default:   req_region = RG_NONE;
      endcase
    end

    case (i_req_size)
      SZ_B, SZ_H, SZ_W: size_ok = 1'b1;
      SZ_BU, SZ_HU:     size_ok = !i_req_wren;
      default:          size_ok = 1'b0;
    endcase

    case (i_req_size)
      SZ_H, SZ_HU: align_ok = !i_req_addr[0];
      SZ_W:        align_ok = (i_req_addr[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase

    req_err = !size_ok || !align_ok || (req_region == RG_NONE) ||
              (i_req_wren && (req_region == RG_SW));

    case (req_region)
      RG_LEDR:  io_word = ledr_reg;
      RG_LEDG:  io_word = ledg_reg;
      RG_HEXLO: io_word = hex_lo_reg;
      RG_HEXHI: io_word = hex_hi_reg;
      RG_LCD:   io_word = lcd_reg;
      RG_SW:    io_word = sw_sync_reg;
      default:  io_word = 32'h0;
    endcase
    io_rdata = load_extend(io_word, i_req_addr[1:0], i_req_size);
  end

  assign wr_be   = byte_en(addr_reg[1:0], size_reg);
  assign wr_mask = lane_mask(wr_be);
  assign wr_data = wdata_reg << {addr_reg[1:0], 3'b000};

  // Reads are launched on the accept edge, so in IDLE the RAM sees the live address.
  assign ram_addr = (state_reg == IDLE) ? i_req_addr[AW+1:2] : addr_reg[AW+1:2];
  assign ram_we   = (state_reg == RESP && wren_reg && !rsp_err_reg && region_reg == RG_RAM)
                    ? wr_be : 4'b0000;
  assign ram_load = load_extend(ram_rdata, addr_reg[1:0], size_reg);

  // With no wait states the RAM word only arrives during RESP itself.
  assign zero_wait_load = (RAM_WAIT == 0) && (state_reg == RESP) && (region_reg == RG_RAM) &&
                          !wren_reg && !rsp_err_reg;

  dmem_sp_ram #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(AW)) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= i_io_sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      wren_reg      <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= '0;
      region_reg    <= RG_NONE;
      rsp_vld_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      ledr_reg      <= '0;
      ledg_reg      <= '0;
      hex_lo_reg    <= '0;
      hex_hi_reg    <= '0;
      lcd_reg       <= '0;
    end else begin
      rsp_vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_req_vld) begin
            wren_reg   <= i_req_wren;
            addr_reg   <= i_req_addr[AW+1:0];
            wdata_reg  <= i_req_wdata;
            size_reg   <= i_req_size;
            region_reg <= req_region;
            if (req_err) begin
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              rsp_vld_reg   <= 1'b1;
              state_reg     <= RESP;
            end else if (req_region == RG_RAM && RAM_WAIT > 0) begin
              cnt_reg   <= 4'(RAM_WAIT - 1);
              state_reg <= WAIT;
            end else begin
              rsp_err_reg   <= 1'b0;
              rsp_rdata_reg <= (i_req_wren || req_region == RG_RAM) ? 32'h0 : io_rdata;
              rsp_vld_reg   <= 1'b1;
              state_reg     <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= wren_reg ? 32'h0 : ram_load;
            rsp_vld_reg   <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          if (zero_wait_load) rsp_rdata_reg <= ram_load;
          if (wren_reg && !rsp_err_reg) begin
            case (region_reg)
              RG_LEDR:  ledr_reg   <= (ledr_reg & ~wr_mask) | (wr_data & wr_mask);
              RG_LEDG:  ledg_reg   <= (ledg_reg & ~wr_mask) | (wr_data & wr_mask);
              RG_HEXLO: hex_lo_reg <= (hex_lo_reg & ~wr_mask) | (wr_data & wr_mask & HEX_MASK);
              RG_HEXHI: hex_hi_reg <= (hex_hi_reg & ~wr_mask) | (wr_data & wr_mask & HEX_MASK);
              RG_LCD:   lcd_reg    <= (lcd_reg & ~wr_mask) | (wr_data & wr_mask);
              default:  ;
            endcase
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_req_rdy   = (state_reg == IDLE);
  assign o_rsp_vld   = rsp_vld_reg;
  assign o_rsp_err   = rsp_err_reg;
  assign o_rsp_rdata = zero_wait_load ? ram_load : rsp_rdata_reg;

  assign o_io_ledr = ledr_reg;
  assign o_io_ledg = ledg_reg;
  assign o_io_lcd  = lcd_reg;
  assign o_io_hex0 = hex_lo_reg[6:0];
  assign o_io_hex1 = hex_lo_reg[14:8];
  assign o_io_hex2 = hex_lo_reg[22:16];
  assign o_io_hex3 = hex_lo_reg[30:24];
  assign o_io_hex4 = hex_hi_reg[6:0];
  assign o_io_hex5 = hex_hi_reg[14:8];
  assign o_io_hex6 = hex_hi_reg[22:16];
  assign o_io_hex7 = hex_hi_reg[30:24];

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed requests push expected
// responses; a negedge monitor pops and compares data, error and latency.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0, req_wren = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] io_sw = '0;
  logic        req_rdy, rsp_vld, rsp_err;
  logic [31:0] rsp_rdata, io_ledr, io_ledg, io_lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  mem_io_responder dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_wren(req_wren),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
    .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .i_io_sw(io_sw), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(io_lcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_vld === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        $display("rsp %s: rdata=%h err=%b cyc=%0d", e.name, rsp_rdata, rsp_err, cyc);
        chk({e.name, " rdata"}, rsp_rdata, e.rdata);
        chk({e.name, " err"}, {31'b0, rsp_err}, {31'b0, e.err});
        chk({e.name, " latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // w = expected wait states; response expected at accept-edge count + 1 + w.
  task automatic issue(input string name, input bit wren, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       input logic [31:0] exp_rdata, input bit exp_err, input int w);
    int n;
    bit ok;
    @(negedge clk);
    req_vld = 1'b1; req_wren = wren; req_addr = addr; req_wdata = wdata; req_size = size;
    n = 0;
    ok = 1'b1;
    while (req_rdy !== 1'b1) begin
      if (n >= 20) begin ok = 1'b0; break; end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s accept: got rdy=%b for 20 cycles, required 1", name, req_rdy);
    end else begin
      sb.push_back('{exp_rdata, exp_err, cyc + 1 + w, name});
    end
    @(negedge clk);
    req_vld = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s response: got none within 40 cycles, required one", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset rdy", {31'b0, req_rdy}, 32'd1);
    chk("reset rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("reset ledr", io_ledr, 32'h0);
    chk("reset hex0", {25'b0, hex0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("SW_100",  1, 32'h0000_0100, 32'hDEAD_BEEF, W,  32'h0, 0, 1);
    issue("LW_100",  0, 32'h0000_0100, 32'h0,         W,  32'hDEAD_BEEF, 0, 1);
    issue("SB_101",  1, 32'h0000_0101, 32'h0000_0080, B,  32'h0, 0, 1);
    issue("LB_101",  0, 32'h0000_0101, 32'h0,         B,  32'hFFFF_FF80, 0, 1);
    issue("LBU_101", 0, 32'h0000_0101, 32'h0,         BU, 32'h0000_0080, 0, 1);
    issue("LW_100b", 0, 32'h0000_0100, 32'h0,         W,  32'hDEAD_80EF, 0, 1);
    issue("LH_102",  0, 32'h0000_0102, 32'h0,         H,  32'hFFFF_DEAD, 0, 1);

    issue("SW_HEXL", 1, 32'h1000_2000, 32'h7F7F_0140, W,  32'h0, 0, 0);
    chk("hex0", {25'b0, hex0}, 32'h40);
    chk("hex1", {25'b0, hex1}, 32'h01);
    chk("hex2", {25'b0, hex2}, 32'h7F);
    chk("hex3", {25'b0, hex3}, 32'h7F);
    chk("hex4 untouched", {25'b0, hex4}, 32'h0);
    chk("ledr untouched", io_ledr, 32'h0);

    issue("LW_102_misal",  0, 32'h0000_0102, 32'h0,         W, 32'h0, 1, 0);
    issue("SW_to_SW",      1, 32'h1001_0000, 32'hFFFF_FFFF, W, 32'h0, 1, 0);
    chk("hex0 after ro store", {25'b0, hex0}, 32'h40);
    chk("ledr after ro store", io_ledr, 32'h0);
    issue("LW_unmapped",   0, 32'h2000_0000, 32'h0,         W, 32'h0, 1, 0);
    issue("LHU_101_misal", 0, 32'h0000_0101, 32'h0,         HU, 32'h0, 1, 0);
    issue("size_011",      0, 32'h0000_0100, 32'h0,         3'b011, 32'h0, 1, 0);
    issue("store_BU",      1, 32'h0000_0100, 32'h0,         BU, 32'h0, 1, 0);
    issue("LW_after_errs", 0, 32'h0000_0100, 32'h0,         W,  32'hDEAD_80EF, 0, 1);

    issue("SB_hex1",  1, 32'h1000_2001, 32'h0000_00FF, B, 32'h0, 0, 0);
    chk("hex1 masked", {25'b0, hex1}, 32'h7F);
    issue("LW_HEXL",  0, 32'h1000_2000, 32'h0, W,  32'h7F7F_7F40, 0, 0);
    issue("SW_LEDR",  1, 32'h1000_0000, 32'hA5A5_0001, W, 32'h0, 0, 0);
    chk("ledr", io_ledr, 32'hA5A5_0001);
    issue("LH_LEDR2", 0, 32'h1000_0002, 32'h0, H,  32'hFFFF_A5A5, 0, 0);
    issue("LHU_LEDR2",0, 32'h1000_0002, 32'h0, HU, 32'h0000_A5A5, 0, 0);

    issue("SW_last",  1, 32'h0000_1FFC, 32'h1234_5678, W, 32'h0, 0, 1);
    issue("LW_last",  0, 32'h0000_1FFC, 32'h0, W, 32'h1234_5678, 0, 1);
    issue("LW_end",   0, 32'h0000_2000, 32'h0, W, 32'h0, 1, 0);

    @(negedge clk);
    io_sw = 32'h0000_1234;
    repeat (2) @(negedge clk);
    issue("LW_SW",    0, 32'h1001_0000, 32'h0, W, 32'h0000_1234, 0, 0);

    // Valid held high: accepts every third cycle, ready low in WAIT and RESP.
    @(negedge clk);
    req_vld = 1'b1; req_wren = 1'b0; req_addr = 32'h0000_0100; req_size = W;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rdy_hold_%0d", i), {31'b0, req_rdy}, {31'b0, (i % 3) == 0});
      if (req_rdy === 1'b1) sb.push_back('{32'hDEAD_80EF, 1'b0, cyc + 2, "LW_hold"});
      @(negedge clk);
    end
    req_vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold queue drained", 32'(sb.size()), 32'd0);

    issue("SW_200",   1, 32'h0000_0200, 32'h1111_1111, W, 32'h0, 0, 1);
    @(negedge clk);
    req_vld = 1'b1; req_wren = 1'b1; req_addr = 32'h0000_0200; req_wdata = 32'h2222_2222;
    req_size = W;
    chk("abort accept rdy", {31'b0, req_rdy}, 32'd1);
    @(negedge clk);
    req_vld = 1'b0;
    chk("abort in WAIT rdy", {31'b0, req_rdy}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async reset ledr", io_ledr, 32'h0);
    chk("async reset rdy", {31'b0, req_rdy}, 32'd1);
    chk("async reset rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("LW_200",   0, 32'h0000_0200, 32'h0, W, 32'h1111_1111, 0, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the MEM-stage load/store interface. It serves one request at a time from the memory stage over a valid/ready request channel and a single-cycle response pulse.
- Address decode selects data RAM, the output peripheral registers (LEDR, LEDG, HEX0-7, LCD) or the switch input.
- Byte/half/word sizing, sign extension, misalignment and unmapped-address errors, and RAM wait states are handled inside the block.
- Peripheral registers drive board I/O directly.

Parameters:
- DEPTH_WORDS, 2048, data RAM size in 32-bit words (power of 2).
- RAM_WAIT, 1, extra wait cycles for RAM accesses (0..15). I/O accesses take 0 wait cycles.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  request ready; high only in IDLE.
- i_req_wren  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_size  in  3  access size. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are loads only.
- o_rsp_vld  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load data, sign/zero extended; 0 for stores and on error.
- o_rsp_err  out  1  misaligned, unmapped, illegal size, or store to a read-only address.
- i_io_sw  in  32  switches, asynchronous to i_clk.
- o_io_ledr  out  32  LEDR register.
- o_io_ledg  out  32  LEDG register.
- o_io_hex0 .. o_io_hex7  out  7 each  7-segment registers.
- o_io_lcd  out  32  LCD register.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - FSM goes to IDLE.
  - All peripheral registers, o_rsp_vld, o_rsp_err and o_rsp_rdata go to 0.
  - RAM contents are not cleared.
  - Reset during WAIT or RESP abandons the request: no response, and no write is committed.
- Memory map (word-aligned bases):
  - 0x0000_0000 to 4*DEPTH_WORDS-1: RAM, read/write.
  - 0x1000_0000: LEDR.
  - 0x1000_1000: LEDG.
  - 0x1000_2000: HEX0-3, bytes [6:0],[14:8],[22:16],[30:24] of the word.
  - 0x1000_3000: HEX4-7, same byte packing.
  - 0x1000_4000: LCD.
  - 0x1001_0000: SW, read-only.
  - Any other address: unmapped.
  - Peripheral registers are readable.
- Switch synchroniser: i_io_sw passes through a 2-flop synchroniser. Reads see the synchronised value.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: o_req_rdy = 1. A request is accepted on a cycle where i_req_vld and o_req_rdy are both high. The block captures wren, addr, wdata and size.
  - IDLE -> WAIT when the access is a valid RAM access and RAM_WAIT > 0. The wait counter is loaded with RAM_WAIT-1.
  - IDLE -> RESP otherwise: I/O access, error, or RAM_WAIT = 0.
  - WAIT: counter decrements each cycle. WAIT -> RESP when the counter reaches 0.
  - RESP: o_rsp_vld = 1 for exactly one cycle, with rdata/err valid. RESP -> IDLE unconditionally.
  - A new request is accepted no earlier than the cycle after RESP.
- Latency: a request accepted in cycle N responds in cycle N+1+W. W = RAM_WAIT for valid RAM accesses, 0 otherwise. Throughput is one request per 2+W cycles.
- Stores:
  - The write commits on the RESP cycle edge, i.e. visible to a load accepted afterwards.
  - Byte enables come from addr[1:0] and size. SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes.
  - Only the enabled bytes of the target change.
  - HEX registers store only bits [6:0] of each byte lane.
- Loads:
  - The aligned word is read and the lane is selected by addr[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
  - Read-data capture is registered into o_rsp_rdata during the cycle before RESP.
- Errors (o_rsp_err = 1, o_rsp_rdata = 0, no state change, 0 wait states):
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - Unmapped address.
  - Store to SW.
  - Store with size BU/HU.
  - Size codes 011, 110, 111.
- While not in RESP, o_rsp_vld = 0 and o_rsp_rdata/o_rsp_err hold their last values.

Decomposition:
- Package mem_io_pkg holds:
  - typedef enum for state_e {IDLE, WAIT, RESP}.
  - size codes SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU.
  - address base constants and the I/O region mask.
- One sub-module, dmem_sp_ram: single-port synchronous RAM with 4-bit byte-enable write and registered read, parameterised by DEPTH_WORDS.
- Decode, alignment/extension, FSM and peripheral registers stay in the top module.

Test Plan:
- Reset released, RAM_WAIT = 1.
  - SW 0xDEADBEEF to 0x100, then LW 0x100 -> rdata 0xDEADBEEF, err 0.
  - Response exactly 2 cycles after accept.
- SB 0x80 to 0x101, then:
  - LB 0x101 -> 0xFFFFFF80.
  - LBU 0x101 -> 0x00000080.
  - LW 0x100 -> 0xDEAD80EF.
- SW 0x7F7F_0140 to 0x1000_2000 -> hex0 = 0x40, hex1 = 0x01, hex2 = 0x7F, hex3 = 0x7F; other outputs unchanged.
- LW 0x0000_0102 -> err 1, rdata 0.
- SW to 0x1001_0000 -> err 1, no register changes.
- LW 0x2000_0000 -> err 1.
- All three error responses come 1 cycle after accept.
- i_io_sw = 0x0000_1234, then after 2 clocks LW 0x1001_0000 -> 0x00001234.
- i_req_vld held high continuously -> o_req_rdy low during WAIT and RESP; exactly one response per accept.
- Assert i_reset low during WAIT of an SW to 0x200, then read 0x200 after reset -> old value retained; no o_rsp_vld pulse for the aborted request.
